// File: rtl/spi_ram_pkg.sv
// SPI burst RAM shared definitions.
// Command codes and FSM state encoding.
package spi_ram_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WRITE,
        TURN,
        READ,
        HOLD
    } state_t;

endpackage

// File: rtl/spi_ram_if.sv
// SPI serial bus bundle.
// master = host side, slave = RAM side.
interface spi_ram_if;

    logic ss_n;
    logic MOSI;
    logic MISO;
    logic frame_err;

    modport master (
        output ss_n,
        output MOSI,
        input  MISO,
        input  frame_err
    );

    modport slave (
        input  ss_n,
        input  MOSI,
        output MISO,
        output frame_err
    );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-port storage for the SPI RAM.
// Synchronous write and read, no reset.
module spi_ram_mem #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // One shared address: write when enabled, always register read data.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/spi_ram_burst.sv
// SPI slave burst RAM: command FSM, pointers and serial datapath.
// Read data is prefetched so MISO streams without gaps.
module spi_ram_burst
    import spi_ram_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic     clk,
    input  logic     rst,
    spi_ram_if.slave bus
);

    localparam int SW    = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int CNT_W = $clog2(SW);

    state_t state, state_nx;

    logic              cmd_hi;
    logic [CNT_W-1:0]  cnt;
    logic [SW-2:0]     sh_in;
    logic [DATA_W-2:0] sh_out;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] addr_word;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] wdata;
    logic              miso_q;
    logic              err_q;
    logic              we;
    logic              abort;
    logic              addr_last;
    logic              data_last;

    assign addr_last = cnt == CNT_W'(ADDR_W - 1);
    assign data_last = cnt == CNT_W'(DATA_W - 1);
    assign addr_word = {sh_in[ADDR_W-2:0], bus.MOSI};
    assign wdata     = {sh_in[DATA_W-2:0], bus.MOSI};

    assign bus.MISO      = miso_q;
    assign bus.frame_err = err_q;

    spi_ram_mem #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk   (clk),
        .we    (we),
        .addr  (mem_addr),
        .wdata (wdata),
        .rdata (rdata)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: ss_n high always returns to IDLE.
    always_comb begin
        state_nx = state;
        if (bus.ss_n) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: state_nx = CMD;
                CMD: begin
                    unique case ({cmd_hi, bus.MOSI})
                        CMD_WR_ADDR,
                        CMD_RD_ADDR: state_nx = ADDR;
                        CMD_WR_DATA: state_nx = WRITE;
                        CMD_RD_DATA: state_nx = TURN;
                    endcase
                end
                ADDR: if (addr_last) state_nx = HOLD;
                TURN: state_nx = READ;
                default: state_nx = state;
            endcase
        end
    end

    // Memory control and abort detection; READ prefetches the next word.
    always_comb begin
        we       = 1'b0;
        abort    = 1'b0;
        mem_addr = rd_ptr;
        unique case (state)
            WRITE: begin
                mem_addr = wr_ptr;
                we       = !bus.ss_n && data_last;
                abort    = bus.ss_n && (cnt != '0);
            end
            READ: mem_addr = rd_ptr + ADDR_W'(1);
            CMD,
            ADDR: abort = bus.ss_n;
            default: ;
        endcase
    end

    // Datapath: shifters, counter, pointers, MISO and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_hi <= 1'b0;
            cnt    <= '0;
            sh_in  <= '0;
            sh_out <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            miso_q <= 1'b0;
            err_q  <= 1'b0;
        end else if (bus.ss_n) begin
            cmd_hi <= 1'b0;
            cnt    <= '0;
            sh_in  <= '0;
            sh_out <= '0;
            miso_q <= 1'b0;
            if (abort) err_q <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    cmd_hi <= bus.MOSI;
                    cnt    <= '0;
                    miso_q <= 1'b0;
                end
                ADDR: begin
                    sh_in  <= {sh_in[SW-3:0], bus.MOSI};
                    miso_q <= 1'b0;
                    if (addr_last) begin
                        cnt <= '0;
                        if (cmd_hi) rd_ptr <= addr_word;
                        else        wr_ptr <= addr_word;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    sh_in  <= {sh_in[SW-3:0], bus.MOSI};
                    miso_q <= 1'b0;
                    if (data_last) begin
                        cnt    <= '0;
                        wr_ptr <= wr_ptr + ADDR_W'(1);
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                TURN: begin
                    sh_out <= rdata[DATA_W-2:0];
                    miso_q <= rdata[DATA_W-1];
                    cnt    <= '0;
                end
                READ: begin
                    if (data_last) begin
                        sh_out <= rdata[DATA_W-2:0];
                        miso_q <= rdata[DATA_W-1];
                        cnt    <= '0;
                        rd_ptr <= rd_ptr + ADDR_W'(1);
                    end else begin
                        sh_out <= {sh_out[DATA_W-3:0], 1'b0};
                        miso_q <= sh_out[DATA_W-2];
                        cnt    <= cnt + CNT_W'(1);
                    end
                end
                default: miso_q <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ram_burst.sv
// Bench for spi_ram_burst: frame-level memory model, per-cycle output compare.
// Two instances cover the 8/8 and 4/16 geometries.
module tb_spi_ram_burst;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] ss = 2'b11;
    logic [1:0] mosi = 2'b00;
    wire  [1:0] miso;
    wire  [1:0] ferr;

    always #5 clk = ~clk;

    spi_ram_if ifa();
    spi_ram_if ifb();

    assign ifa.ss_n = ss[0];
    assign ifa.MOSI = mosi[0];
    assign ifb.ss_n = ss[1];
    assign ifb.MOSI = mosi[1];
    assign miso = {ifb.MISO, ifa.MISO};
    assign ferr = {ifb.frame_err, ifa.frame_err};

    spi_ram_burst #(.ADDR_W(8), .DATA_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    spi_ram_burst #(.ADDR_W(4), .DATA_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    int aw [2] = '{8, 4};
    int dw [2] = '{8, 16};

    logic [15:0] mm [2][256];
    bit          kn [2][256];
    int          wp [2];
    int          rp [2];
    logic        e_miso [2];
    logic        e_err [2];
    bit          e_skip [2];
    logic [15:0] capw [4];

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, a, e);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int w = 0; w < 2; w++) begin
            if (!e_skip[w]) chk($sformatf("miso%0d", w), 32'(miso[w]), 32'(e_miso[w]));
            chk($sformatf("frame_err%0d", w), 32'(ferr[w]), 32'(e_err[w]));
        end
    end

    task automatic step(input int w, input logic s, input logic m,
                        input logic em, input bit sk);
        @(negedge clk);
        ss[w]     = s;
        mosi[w]   = m;
        e_miso[w] = em;
        e_skip[w] = sk;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            wp[w]     = 0;
            rp[w]     = 0;
            e_err[w]  = 1'b0;
            e_miso[w] = 1'b0;
            e_skip[w] = 1'b0;
        end
    endtask

    task automatic frame(input int w, input int cmd, input logic [31:0] pay,
                         input int nb, input int nw);
        int W, D, tot, j, a;
        logic m, em;
        bit sk;
        logic [31:0] mask;
        W = dw[w];
        D = 1 << aw[w];
        mask = (32'd1 << W) - 1;
        tot = (cmd == 3) ? 2 + nw * W : 2 + nb;
        for (int i = 0; i < 4; i++) capw[i] = '0;
        for (int k = 1; k <= tot; k++) begin
            m = 1'b0;
            em = 1'b0;
            sk = 1'b0;
            if (k == 1) m = cmd[1];
            else if (k == 2) m = cmd[0];
            else if (cmd != 3) m = pay[nb - 1 - (k - 3)];
            else begin
                j  = k - 3;
                a  = (rp[w] + j / W) % D;
                em = mm[w][a][W - 1 - j % W];
                sk = !kn[w][a];
            end
            step(w, 1'b0, m, em, sk);
            if (cmd == 3 && k >= 3)
                capw[(k-3)/W] = (capw[(k-3)/W] << 1) | 16'(miso[w]);
        end
        if ((cmd == 0 || cmd == 2) && nb < aw[w]) e_err[w] = 1'b1;
        if (cmd == 1 && nb % W != 0) e_err[w] = 1'b1;
        step(w, 1'b1, 1'b0, 1'b0, 1'b0);
        case (cmd)
            0: if (nb >= aw[w]) wp[w] = int'((pay >> (nb - aw[w])) & 32'(D - 1));
            2: if (nb >= aw[w]) rp[w] = int'((pay >> (nb - aw[w])) & 32'(D - 1));
            1: for (int i = 0; i < nb / W; i++) begin
                mm[w][wp[w]] = 16'((pay >> (nb - (i + 1) * W)) & mask);
                kn[w][wp[w]] = 1'b1;
                wp[w] = (wp[w] + 1) % D;
            end
            default: if (nw > 0) rp[w] = (rp[w] + nw - 1) % D;
        endcase
        step(w, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_miso", 32'(miso), 32'd0);
        chk("reset_err", 32'(ferr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        frame(0, 0, 32'h10, 8, 0);
        frame(0, 1, 32'hA55A, 16, 0);
        frame(0, 2, 32'h10, 8, 0);
        frame(0, 3, 32'h0, 0, 2);
        chk("rd_a5", 32'(capw[0]), 32'h00A5);
        chk("rd_5a", 32'(capw[1]), 32'h005A);

        frame(0, 0, 32'hFF, 8, 0);
        frame(0, 1, 32'h1122, 16, 0);
        frame(0, 2, 32'hFF, 8, 0);
        frame(0, 3, 32'h0, 0, 2);
        chk("wrap_11", 32'(capw[0]), 32'h0011);
        chk("wrap_22", 32'(capw[1]), 32'h0022);

        frame(0, 0, 32'h31, 8, 0);
        frame(0, 1, 32'h3C, 8, 0);
        frame(0, 0, 32'h30, 8, 0);
        frame(0, 1, 32'h77, 8, 0);
        frame(0, 1, 32'h1F, 5, 0);
        chk("abort_err", 32'(ferr[0]), 32'd1);
        frame(0, 2, 32'h30, 8, 0);
        frame(0, 3, 32'h0, 0, 2);
        chk("abort_77", 32'(capw[0]), 32'h0077);
        chk("abort_3c", 32'(capw[1]), 32'h003C);
        frame(0, 1, 32'h88, 8, 0);
        frame(0, 3, 32'h0, 0, 1);
        chk("abort_wp", 32'(capw[0]), 32'h0088);

        frame(0, 0, 32'h40, 8, 0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        mosi[0] = 1'b1;
        #2;
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        chk("rst_miso", 32'(miso[0]), 32'd0);
        chk("rst_err", 32'(ferr[0]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ss[0] = 1'b1;
        mosi[0] = 1'b0;
        step(0, 1'b1, 1'b0, 1'b0, 1'b0);
        frame(0, 1, 32'hC3, 8, 0);
        frame(0, 2, 32'h00, 8, 0);
        frame(0, 3, 32'h0, 0, 1);
        chk("rst_next", 32'(capw[0]), 32'h00C3);

        frame(1, 0, 32'h7D, 7, 0);
        frame(1, 1, 32'hBEEF, 16, 0);
        frame(1, 2, 32'h3C, 6, 0);
        frame(1, 3, 32'h0, 0, 1);
        chk("b_beef", 32'(capw[0]), 32'hBEEF);
        frame(1, 0, 32'hF, 4, 0);
        frame(1, 1, 32'h1234_5678, 32, 0);
        frame(1, 2, 32'hF, 4, 0);
        frame(1, 3, 32'h0, 0, 2);
        chk("b_wrap0", 32'(capw[0]), 32'h1234);
        chk("b_wrap1", 32'(capw[1]), 32'h5678);
        chk("b_err", 32'(ferr[1]), 32'd0);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_burst.md
SPI_RAM_BURST -- requirements
Module: spi_ram_burst

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, memory address width; DEPTH = 2**ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 8, memory word width (legal 4..32).
REQ-003 The block SHALL have port clk  input  1  single clock; all sampling and driving on rising edge.
REQ-004 The block SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port ss_n  input  1  active-low slave select; a frame is one contiguous low period.
REQ-006 The block SHALL have port MOSI  input  1  serial data in, MSB first.
REQ-007 The block SHALL have port MISO  output  1  serial data out, MSB first, registered.
REQ-008 The block SHALL have port frame_err  output  1  sticky flag: frame ended mid-field.

Function
REQ-009 Each frame SHALL start with a 2-bit command: 00 WR_ADDR, 01 WR_DATA, 10 RD_ADDR, 11 RD_DATA.
REQ-010 The FSM SHALL have states IDLE, CMD, ADDR, WRITE, TURN, READ and HOLD.
REQ-011 IDLE: on an edge with ss_n=0, MOSI SHALL be captured as cmd[1] and the FSM SHALL go to CMD.
REQ-012 CMD: the edge SHALL capture cmd[0] and go to ADDR (00/10), WRITE (01) or TURN (11).
REQ-013 ADDR: the FSM SHALL shift in exactly ADDR_W bits.
REQ-014 On the ADDR_W-th edge the FSM SHALL load wr_ptr (cmd 00) or rd_ptr (cmd 10) and go to HOLD.
REQ-015 HOLD: remaining MOSI bits SHALL be ignored until ss_n rises.
REQ-016 WRITE: every DATA_W edges SHALL write the assembled word to mem[wr_ptr] on the last edge.
REQ-017 After each such write, wr_ptr SHALL increment and the FSM SHALL stay in WRITE (burst).
REQ-018 TURN: exactly one edge SHALL elapse, during which mem[rd_ptr] is loaded into the shift register.
REQ-019 At the end of TURN, MISO SHALL show the word MSB and the FSM SHALL go to READ.
REQ-020 READ: each edge SHALL shift MISO one bit.
REQ-021 On the DATA_W-th edge of a word, rd_ptr SHALL increment and mem[rd_ptr+1] SHALL load, so MISO output is gapless.
REQ-022 Pointers SHALL wrap DEPTH-1 -> 0 with no error.
REQ-023 ss_n high on any edge SHALL force IDLE and set MISO to 0.
REQ-024 If ss_n rises with a partial address or data word collected, the block SHALL discard that field, make no memory write and no pointer change, and set frame_err.
REQ-025 frame_err SHALL NOT be set for an ss_n rise in IDLE, HOLD, or at a READ word boundary.
REQ-026 A read and a write to the same address cannot coincide (one frame, one command); memory SHALL be single-port.
REQ-027 MISO SHALL be 0 in all states except READ and the cycle after TURN.

Reset
REQ-028 rst=1 SHALL immediately set: FSM IDLE, wr_ptr=0, rd_ptr=0, bit counter 0, shift registers 0, MISO=0, frame_err=0.
REQ-029 Memory contents SHALL NOT be reset.
REQ-030 Reset mid-frame SHALL abort with no write; after reset release the block SHALL wait for the next ss_n-low edge in IDLE.

Structure
REQ-031 Package spi_ram_pkg SHALL hold the command codes (CMD_WR_ADDR, CMD_WR_DATA, CMD_RD_ADDR, CMD_RD_DATA) and the FSM state enumeration.
REQ-032 Storage SHALL be a sub-module spi_ram_mem, parameterised by ADDR_W and DATA_W, with synchronous write and synchronous read and no reset.
REQ-033 Protocol FSM, pointers, counters and frame_err SHALL reside in spi_ram_burst.

Verification (ADDR_W=8, DATA_W=8)
REQ-034 Frame 00+0x10, then frame 01+0xA5,0x5A, then frame 10+0x10, then frame 11 + 16 clocks -> MISO = 0xA5 then 0x5A, with no gap after the TURN edge.
REQ-035 WR_ADDR 0xFF, burst write 0x11,0x22; read from 0xFF for 2 words -> 0x11, 0x22 (wrap to address 0).
REQ-036 WR_DATA frame aborted after 5 data bits -> addressed word unchanged, wr_ptr unchanged, frame_err=1.
REQ-037 rst pulse during the third bit of a WR_DATA word -> no write, MISO=0, frame_err=0; next full frame operates normally.
REQ-038 Rerun the first scenario with ADDR_W=4, DATA_W=16 using 0xBEEF at address 0xF -> readback 0xBEEF; extra HOLD bits after an address are ignored.
